mont_mult_unit: RTL and testbench

Bit-serial radix-2 Montgomery modular multiplier computing result = a·b·2^(−WIDTH) mod m. Sits directly downstream of the operand selection mux in the RSA datapath. The mux output (constant one, message or running result) drives operand `a` or `b`. The exponentiation controller issues `start` and waits for `done` before reselecting operands.

---
 rtl/mont_mult_unit.sv | 152 +++++++++++++++
 tb/tb_mont_mult_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult_unit.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^(-WIDTH) mod m.
// Optional operand legality check enabled by defining MONT_OPERAND_CHECK_EN.
module mont_mult_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CORR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [RW-1:0]    t_add;
    logic [RW-1:0]    t_odd;
    logic [RW-1:0]    r_corr;
    logic             bad_ops;

`ifdef MONT_OPERAND_CHECK_EN
    logic             err_q, err_d;
    logic             bad_q, bad_d;

    assign bad_ops = !m[0] || (a >= m) || (b >= m);
    assign err     = err_q;
`else
    assign bad_ops = 1'b0;
    assign err     = 1'b0;
`endif

    // a_q is shifted right each iteration, so bit 0 is always the current multiplier bit
    always_comb begin
        t_add  = r_q + (a_q[0] ? {2'b00, b_q} : {RW{1'b0}});
        t_odd  = t_add[0] ? (t_add + {2'b00, m_q}) : t_add;
        r_corr = (r_q >= {2'b00, m_q}) ? (r_q - {2'b00, m_q}) : r_q;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        result_d = result_q;
        r_d      = r_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
        err_d    = err_q;
        bad_d    = bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    r_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = bad_ops ? CORR : CALC;
`ifdef MONT_OPERAND_CHECK_EN
                    bad_d   = bad_ops;
`endif
                end
            end
            CALC: begin
                r_d = t_odd >> 1;
                a_d = a_q >> 1;
                i_d = i_q + 1'b1;
                if (i_q == CW'(WIDTH - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                result_d = r_corr[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef MONT_OPERAND_CHECK_EN
                err_d    = bad_q;
                if (bad_q) begin
                    result_d = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            r_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            result_q <= result_d;
            r_q      <= r_d;
            i_q      <= i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MONT_OPERAND_CHECK_EN
            err_q    <= err_d;
            bad_q    <= bad_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_mult_unit.sv
// Scoreboard bench for mont_mult_unit: directed cases plus randomized legal operands,
// checked against a modular-arithmetic reference model.
module tb_mont_mult_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] m = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] hold_res = '0;
    bit           tb_done = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        bit           chk;
        int           due;
    } exp_t;

    exp_t sb[$];

    mont_mult_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .m      (m),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the unique r in [0,m) with r*2^W == a*b (mod m)
    function automatic int mont_ref(input int ia, input int ib, input int im);
        int p;
        p = (ia * ib) % im;
        for (int r = 0; r < im; r++) begin
            if (((r << W) % im) == p) return r;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Called at a negedge; drives one start cycle and records the expected response.
    task automatic issue(input int ia, input int ib, input int im);
        exp_t e;
        bit   legal;
        legal = (im % 2 == 1) && (ia < im) && (ib < im);
        start = 1'b1;
        a = W'(ia);
        b = W'(ib);
        m = W'(im);
        e.chk = legal;
        e.err = 1'b0;
        e.res = legal ? W'(mont_ref(ia, ib, im)) : '0;
        e.due = cyc + 1 + W + 1;
`ifdef MONT_OPERAND_CHECK_EN
        if (!legal) begin
            e.chk = 1;
            e.err = 1'b1;
            e.res = '0;
            e.due = cyc + 2;
        end
`endif
        sb.push_back(e);
        $display("issue a=%0d b=%0d m=%0d exp=%0d err=%0d due=%0d", ia, ib, im, e.res, e.err, e.due);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("wait_done_timeout", 0, 1);
    endtask

    // Monitor: pops the scoreboard on every done, and checks result holds otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !tb_done) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.due);
                        chk("err", int'(err), int'(e.err));
                        if (e.chk) chk("result", int'(result), int'(e.res));
                        hold_res = e.chk ? e.res : result;
                        $display("done cycle=%0d result=%0d err=%0d", cyc, result, err);
                    end
                end else begin
                    if (sb.size() > 0 && cyc > sb[0].due) begin
                        chk("missing_done", cyc, sb[0].due);
                        void'(sb.pop_front());
                    end
                    chk("result_hold", int'(result), int'(hold_res));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(5, 7, 13);
        wait_idle();
        issue(12, 11, 13);
        wait_idle();

        // back-to-back: second start during the done cycle
        issue(12, 12, 13);
        wait_done();
        issue(1, 1, 13);
        wait_idle();

        // reset mid-calculation discards the job
        @(negedge clk);
        issue(5, 7, 13);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 hold_res = '0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_done", int'(done), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(5, 7, 13);
        wait_idle();

        // start while busy is ignored
        @(negedge clk);
        issue(12, 11, 13);
        start = 1'b1;
        a = 4'd1;
        b = 4'd2;
        m = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // illegal (even) modulus
        @(negedge clk);
        issue(1, 1, 12);
        wait_idle();

        for (int n = 0; n < 30; n++) begin
            int im, ia, ib;
            im = 2 * $urandom_range(1, 7) + 1;
            ia = $urandom_range(0, im - 1);
            ib = $urandom_range(0, im - 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ia, ib, im);
            wait_idle();
        end

        for (int k = 0; k < 40 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
        tb_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
